// File: rtl/med_dispense_ctrl.sv
// Medication dispense controller: turns dose-due edges into serialised,
// timed actuator pulses and tracks per-compartment pill stock.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   med_0..med_3          dose-due levels from the scheduler
//   refill/_sel/_qty      one-cycle refill strobe, compartment, pill count
//   act[3:0]              actuator drive, one-hot or zero, registered
//   busy                  high while firing or in the post-pulse gap
//   dose_done             one-cycle pulse when a dose completes
//   low/empty/missed[3:0] per-compartment stock and missed-dose status
module med_dispense_ctrl #(
    parameter int PULSE_LEN  = 4,
    parameter int GAP_LEN    = 2,
    parameter int INV_W      = 7,
    parameter int LOW_THRESH = 5,
    parameter int INIT_STOCK = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             med_0,
    input  logic             med_1,
    input  logic             med_2,
    input  logic             med_3,
    input  logic             refill,
    input  logic [1:0]       refill_sel,
    input  logic [INV_W-1:0] refill_qty,
    output logic [3:0]       act,
    output logic             busy,
    output logic             dose_done,
    output logic [3:0]       low,
    output logic [3:0]       empty,
    output logic [3:0]       missed
);

    localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, FIRE, GAP} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [1:0]        sel, sel_nx, pick_idx;
    logic [3:0]        med, prev, req;
    logic [3:0]        pending, pending_nx, missed_nx;
    logic [3:0]        act_nx, elig, clr, miss_set, rf_clr;
    logic              done_nx, dec, launch;
    logic [INV_W-1:0]  stock    [4];
    logic [INV_W-1:0]  stock_nx [4];

    assign med    = {med_3, med_2, med_1, med_0};
    assign req    = med & ~prev;
    assign busy   = (state != IDLE);
    assign elig   = pending & ~empty;
    assign rf_clr = (refill && refill_qty != '0) ? (4'b0001 << refill_sel)
                                                 : 4'b0000;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            empty[i] = (stock[i] == '0);
            low[i]   = !empty[i] && (stock[i] <= INV_W'(LOW_THRESH));
        end
    end

    always_comb begin
        pick_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (elig[i]) pick_idx = 2'(i);
        end
    end

    // The last gap edge doubles as an idle decision so back-to-back
    // doses are separated by exactly GAP_LEN dead cycles.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sel_nx   = sel;
        act_nx   = act;
        done_nx  = 1'b0;
        dec      = 1'b0;
        launch   = 1'b0;
        clr      = 4'b0000;
        miss_set = req & empty;
        case (state)
            IDLE: launch = 1'b1;
            FIRE: begin
                if (cnt == '0) begin
                    act_nx   = 4'b0000;
                    dec      = 1'b1;
                    done_nx  = 1'b1;
                    state_nx = GAP;
                    cnt_nx   = CW'(GAP_LEN - 1);
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            GAP: begin
                if (cnt == '0) launch = 1'b1;
                else           cnt_nx = cnt - CW'(1);
            end
            default: state_nx = IDLE;
        endcase
        if (launch) begin
            state_nx = IDLE;
            // A queued dose whose stock ran out is dropped as missed.
            clr      = pending & empty;
            miss_set = miss_set | (pending & empty);
            if (elig != 4'b0000) begin
                state_nx = FIRE;
                sel_nx   = pick_idx;
                act_nx   = 4'b0001 << pick_idx;
                cnt_nx   = CW'(PULSE_LEN - 1);
                clr      = clr | (4'b0001 << pick_idx);
            end
        end
        // Clear wins so a request on the bit being launched merges.
        pending_nx = (pending | (req & ~empty)) & ~clr;
        missed_nx  = (missed | miss_set) & ~rf_clr;
    end

    // Saturate the refill first, then take the dispensed pill.
    always_comb begin
        logic [INV_W:0] sum;
        for (int i = 0; i < 4; i++) begin
            sum         = {1'b0, stock[i]} + {1'b0, refill_qty};
            stock_nx[i] = stock[i];
            if (refill && refill_sel == 2'(i)) begin
                stock_nx[i] = sum[INV_W] ? '1 : sum[INV_W-1:0];
            end
            if (dec && sel == 2'(i)) begin
                stock_nx[i] = stock_nx[i] - INV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sel       <= 2'd0;
            act       <= 4'b0000;
            dose_done <= 1'b0;
            pending   <= 4'b0000;
            missed    <= 4'b0000;
            prev      <= 4'b0000;
            for (int i = 0; i < 4; i++) stock[i] <= INV_W'(INIT_STOCK);
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            sel       <= sel_nx;
            act       <= act_nx;
            dose_done <= done_nx;
            pending   <= pending_nx;
            missed    <= missed_nx;
            prev      <= med;
            for (int i = 0; i < 4; i++) stock[i] <= stock_nx[i];
        end
    end

endmodule

// File: tb/tb_med_dispense_ctrl.sv
// Testbench for med_dispense_ctrl: vector table, directed corner
// sequences and random traffic against a time-based dose model.
module tb_med_dispense_ctrl;

    localparam int PULSE_LEN  = 4;
    localparam int GAP_LEN    = 2;
    localparam int LOW_THRESH = 5;
    localparam int MAXS       = 127;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       med_0 = 0, med_1 = 0, med_2 = 0, med_3 = 0;
    logic       refill = 0;
    logic [1:0] refill_sel = 0;
    logic [6:0] refill_qty = 0;
    logic [3:0] act, low, empty, missed;
    logic       busy, dose_done;

    int n_total = 0;
    int n_pass  = 0;

    med_dispense_ctrl dut (
        .clk(clk), .reset(reset),
        .med_0(med_0), .med_1(med_1), .med_2(med_2), .med_3(med_3),
        .refill(refill), .refill_sel(refill_sel), .refill_qty(refill_qty),
        .act(act), .busy(busy), .dose_done(dose_done),
        .low(low), .empty(empty), .missed(missed)
    );

    always #5 clk = ~clk;

    // Reference model: doses as time windows (start edge, end edge,
    // earliest next start) instead of a counter-driven state machine.
    int         m_stock [4];
    logic [3:0] m_pend, m_missed, m_prev;
    int         m_cur, m_end, m_free, m_n;
    logic       m_done;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_stock[i] = 0;
        m_pend = 0; m_missed = 0; m_prev = 0;
        m_cur = -1; m_end = 0; m_free = 0; m_n = 0; m_done = 0;
    endfunction

    function automatic void model_step(logic [3:0] m, logic rf,
                                       logic [1:0] s, int q);
        logic [3:0] clr, mset, pset, rclr;
        int dec;
        m_n++;
        m_done = 0; clr = 0; mset = 0; pset = 0; rclr = 0; dec = -1;
        if (m_cur >= 0) begin
            if (m_n == m_end) begin
                dec = m_cur; m_done = 1; m_cur = -1;
                m_free = m_n + GAP_LEN;
            end
        end else if (m_n >= m_free) begin
            for (int i = 0; i < 4; i++)
                if (m_pend[i] && m_stock[i] == 0) begin
                    clr[i] = 1; mset[i] = 1;
                end
            for (int i = 0; i < 4; i++)
                if (m_pend[i] && m_stock[i] > 0 && m_cur < 0) begin
                    m_cur = i; m_end = m_n + PULSE_LEN; clr[i] = 1;
                end
        end
        for (int i = 0; i < 4; i++)
            if (m[i] && !m_prev[i]) begin
                if (m_stock[i] == 0) mset[i] = 1;
                else                 pset[i] = 1;
            end
        if (rf && q > 0) rclr[s] = 1;
        m_pend   = (m_pend | pset) & ~clr;
        m_missed = (m_missed | mset) & ~rclr;
        if (rf) m_stock[s] = (m_stock[s] + q > MAXS) ? MAXS : m_stock[s] + q;
        if (dec >= 0) m_stock[dec]--;
        m_prev = m;
    endfunction

    function automatic logic [17:0] model_vec();
        logic [3:0] a, l, e;
        a = 0; l = 0; e = 0;
        if (m_cur >= 0) a[m_cur] = 1;
        for (int i = 0; i < 4; i++) begin
            e[i] = (m_stock[i] == 0);
            l[i] = (m_stock[i] != 0) && (m_stock[i] <= LOW_THRESH);
        end
        return {a, (m_cur >= 0) || (m_n < m_free), m_done, l, e, m_missed};
    endfunction

    function automatic logic [17:0] dut_vec();
        return {act, busy, dose_done, low, empty, missed};
    endfunction

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, got, exp);
    endtask

    task automatic cycle(input logic [3:0] m, input logic rf = 0,
                         input logic [1:0] s = 0, input logic [6:0] q = 0);
        {med_3, med_2, med_1, med_0} = m;
        refill = rf; refill_sel = s; refill_qty = q;
        @(posedge clk);
        model_step(m, rf, s, int'(q));
        #1;
        check("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic do_reset();
        {med_3, med_2, med_1, med_0} = 4'b0000;
        refill = 0; refill_sel = 0; refill_qty = 0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0] med;
        logic       rf;
        logic [1:0] sel;
        logic [6:0] qty;
        logic [3:0] act;
        logic       busy;
        logic       done;
        logic [3:0] low, empty, missed;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic [3:0] m, logic rf, logic [1:0] s,
                                logic [6:0] q, logic [3:0] a, logic b,
                                logic d, logic [3:0] e);
        vec_t v;
        v.med = m; v.rf = rf; v.sel = s; v.qty = q;
        v.act = a; v.busy = b; v.done = d;
        v.low = 4'b0000; v.empty = e; v.missed = 4'b0000;
        tbl.push_back(v);
    endfunction

    function automatic void add_pulse(logic [3:0] m, int idx);
        for (int k = 0; k < PULSE_LEN; k++)
            add(m, 0, 0, 0, 4'(1 << idx), 1, 0, 0);
        add(m, 0, 0, 0, 0, 1, 1, 0);
        add(m, 0, 0, 0, 0, 1, 0, 0);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int         cnt, spur, f, r;
        logic       pa;
        logic [3:0] e, rmed;
        logic       aq[$];

        // Refill all, single dose on 2, then 0/1/3 together.
        for (int s = 0; s < 4; s++) begin
            e = 4'b1111;
            e = e << (s + 1);
            add(0, 1, 2'(s), 10, 0, 0, 0, e);
        end
        add(4'b0100, 0, 0, 0, 0, 0, 0, 0);
        add_pulse(4'b0100, 2);
        add(4'b0100, 0, 0, 0, 0, 0, 0, 0);
        add(4'b1011, 0, 0, 0, 0, 0, 0, 0);
        add_pulse(4'b1011, 0);
        add_pulse(4'b1011, 1);
        add_pulse(4'b1011, 3);
        add(4'b1011, 0, 0, 0, 0, 0, 0, 0);

        do_reset();
        check("reset_state", 32'(dut_vec()), 32'({4'b0, 1'b0, 1'b0,
              4'b0, 4'b1111, 4'b0}));
        foreach (tbl[k]) begin
            cycle(tbl[k].med, tbl[k].rf, tbl[k].sel, tbl[k].qty);
            check($sformatf("vec%0d", k), 32'(dut_vec()),
                  32'({tbl[k].act, tbl[k].busy, tbl[k].done, tbl[k].low,
                       tbl[k].empty, tbl[k].missed}));
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("s2_stock%0d", i), 32'(dut.stock[i]), 9);

        // Last pill, then a request on an empty compartment.
        do_reset();
        cycle(0, 1, 1, 1);
        check("s3_low_one", 32'(low), 32'(4'b0010));
        cycle(4'b0010);
        repeat (8) cycle(4'b0010);
        check("s3_empty", 32'(empty), 32'(4'b1111));
        check("s3_low_zero", 32'(low), 0);
        cycle(4'b0000);
        cycle(4'b0010);
        check("s3_missed", 32'(missed), 32'(4'b0010));
        spur = 0;
        repeat (6) begin
            cycle(4'b0010);
            if (act != 0) spur++;
        end
        check("s3_no_pulse", spur, 0);
        cycle(4'b0010, 1, 1, 3);
        check("s3_missed_clr", 32'(missed), 0);
        check("s3_low_after", 32'(low), 32'(4'b0010));

        // Held level gives one dose; re-toggle during fire re-queues.
        do_reset();
        cycle(0, 1, 0, 10);
        cnt = 0; pa = 0;
        repeat (50) begin
            cycle(4'b0001);
            if (act[0] && !pa) cnt++;
            pa = act[0];
        end
        check("s4_one_pulse", cnt, 1);
        check("s4_stock", 32'(dut.stock[0]), 9);
        cycle(4'b0000);
        aq.delete();
        cycle(4'b0001); aq.push_back(act[0]);
        cycle(4'b0001); aq.push_back(act[0]);
        cycle(4'b0000); aq.push_back(act[0]);
        cycle(4'b0001); aq.push_back(act[0]);
        repeat (16) begin cycle(4'b0001); aq.push_back(act[0]); end
        f = -1; r = -1; cnt = 0;
        for (int k = 1; k < aq.size(); k++) begin
            if (aq[k] && !aq[k-1]) cnt++;
            if (!aq[k] && aq[k-1] && f < 0) f = k;
            if (aq[k] && !aq[k-1] && f >= 0 && r < 0) r = k;
        end
        check("s4_pulses", cnt, 2);
        check("s4_gap", r - f, GAP_LEN);
        check("s4_stock2", 32'(dut.stock[0]), 7);

        // Saturation and refill on the final fire edge.
        do_reset();
        cycle(0, 1, 3, 126);
        cycle(0, 1, 3, 5);
        check("s5_sat", 32'(dut.stock[3]), 127);
        check("s5_empty", 32'(empty), 32'(4'b0111));
        cycle(4'b1000);
        repeat (PULSE_LEN) cycle(4'b1000);
        cycle(4'b1000, 1, 3, 2);
        check("s5_done", 32'(dose_done), 1);
        check("s5_stock", 32'(dut.stock[3]), 126);

        // Asynchronous reset in the middle of a pulse.
        do_reset();
        cycle(0, 1, 0, 10);
        cycle(0, 1, 1, 10);
        cycle(4'b0011);
        cycle(4'b0011);
        cycle(4'b0011);
        check("s6_firing", 32'(act), 32'(4'b0001));
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check("s6_act_async", 32'(act), 0);
        check("s6_busy_async", 32'(busy), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        spur = 0;
        repeat (20) begin
            cycle(4'b0011);
            if (act != 0) spur++;
        end
        check("s6_no_spurious", spur, 0);
        for (int i = 0; i < 4; i++)
            check($sformatf("s6_stock%0d", i), 32'(dut.stock[i]), 0);

        // Random traffic against the model.
        do_reset();
        rmed = 0;
        for (int k = 0; k < 3000; k++) begin
            logic       rf;
            logic [1:0] s;
            logic [6:0] q;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) rmed[b] = ~rmed[b];
            rf = ($urandom_range(0, 5) == 0);
            s  = 2'($urandom_range(0, 3));
            q  = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(100, 127))
                                              : 7'($urandom_range(0, 12));
            cycle(rmed, rf, s, q);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/med_dispense_ctrl.md
Name: med_dispense_ctrl

Overview:
- Downstream of the mainCounter dose scheduler. Consumes its four dose-due levels (med_0..med_3) and turns each new dose request into one timed actuator pulse for the matching pill compartment.
- Serialises requests so at most one actuator is energised at any time.
- Tracks per-compartment pill stock and raises low-stock, empty and missed-dose status for the alarm/display stage.

Parameters:
PULSE_LEN, 4, clock cycles an actuator is held high per dose (>=1)
GAP_LEN, 2, idle cycles forced between consecutive pulses (>=1)
INV_W, 7, stock counter width per compartment
LOW_THRESH, 5, stock at or below this value (and nonzero) flags low
INIT_STOCK, 0, stock loaded into every compartment on reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
med_0..med_3  input  1 each  dose-due levels from mainCounter
refill  input  1  refill strobe, one cycle
refill_sel  input  2  compartment index for refill
refill_qty  input  INV_W  pills added on refill
act  output  4  actuator drive, one-hot or zero, registered
busy  output  1  high in FIRE or GAP
dose_done  output  1  one-cycle pulse when a dose completes
low  output  4  per-compartment low-stock flag
empty  output  4  per-compartment stock==0 flag
missed  output  4  sticky: dose requested while compartment empty

Behaviour:
- Reset (async, immediate, including mid-pulse):
  - act=0, busy=0, dose_done=0, missed=0, pending=0, edge-detect history=0, FSM=IDLE, gap/pulse counter=0.
  - Every stock=INIT_STOCK; low/empty follow from it.
- Edge detect: med_i sampled 1 with registered previous sample 0 → request. A level held high yields exactly one request.
- Pending:
  - A request sets pending[i]. A second request while pending[i] is set merges (no double dose).
  - If stock[i]==0 at the request edge, pending[i] is not set and missed[i] sets instead.
- FSM states IDLE, FIRE, GAP:
  - IDLE: if any pending bit is set, select the lowest index (fixed priority 0>1>2>3), clear that pending bit, load the pulse counter, and go to FIRE at that edge. act[sel] is high from that edge.
  - FIRE: hold act[sel] for exactly PULSE_LEN cycles. On the final edge: act=0, stock[sel] decrements by 1, dose_done=1 for one cycle, go to GAP.
  - GAP: act=0 for GAP_LEN cycles, then IDLE.
  - A request for the compartment currently firing sets pending again and is served after GAP.
- Latency: a rising med_i sampled at edge E0 (FSM idle, nothing else pending) gives act[i] high after E0+1, low after E0+1+PULSE_LEN. The next pulse cannot start before E0+1+PULSE_LEN+GAP_LEN.
- Stock arithmetic, unsigned INV_W bits:
  - Refill: stock[refill_sel] = min(stock + refill_qty, 2^INV_W-1), saturating. Accepted in any state.
  - Refill and decrement on the same compartment in the same cycle: stock = min(stock + qty, max) - 1, saturation applied before the decrement.
  - Refill with refill_qty>0 clears missed[refill_sel]. A refill with qty 0 changes nothing.
  - A pulse only starts on nonzero stock, so the decrement never underflows.
- Status, combinational from registers:
  - empty[i] = (stock[i]==0).
  - low[i] = (stock[i]!=0 && stock[i]<=LOW_THRESH).
- Simultaneous requests on several compartments: all pending bits set, served one per FIRE/GAP cycle in priority order. A pending lower index always wins at the next IDLE.

Test Plan:
1. Reset with INIT_STOCK=0, then refill each compartment qty=10 → empty=0000, low=0000. Raise med_2 → act=0100 for 4 cycles, dose_done once, stock[2]=9, busy high for 6 cycles total.
2. From scenario 1, raise med_0, med_1, med_3 on the same edge → pulses fire in order 0001, 0010, 1000. Each pulse is 4 cycles with 2 idle cycles between. Stock of each = 9. Never two act bits high at once.
3. stock[1]=1, raise med_1 → one pulse, stock[1]=0, empty[1]=1. Drop and re-raise med_1 → no pulse, missed[1]=1. Refill sel=1 qty=3 → missed[1]=0, low[1]=1.
4. Hold med_0 high for 50 cycles (stock 10) → exactly one pulse, stock[0]=9. Toggle med_0 during its FIRE → second pulse starts 2 cycles after the first ends.
5. stock[3]=126, refill qty=5 → stock 127, saturated. Refill sel=3 qty=2 on the final FIRE edge of compartment 3 at stock 127 → stock 126.
6. Assert reset during cycle 2 of a pulse → act=0000 immediately. After release the FSM is IDLE, all stock=INIT_STOCK, and there is no spurious pulse while med inputs are held high.
